serial_fifo_uart: RTL and testbench
===================================

# serial_fifo_uart

Parametrised successor to the CPU's fixed 8N1 serial converter. It is a full-duplex asynchronous serial port with a programmable bit-clock divider, programmable character width, and receive/transmit FIFOs. It keeps the PDP-8 TTY flag semantics (`rflag`/`rclr`, `tflag`/`tclr`) so the CPU's KSF/KCC/TSF/TLS decode connects unchanged, and it adds buffering, CTS flow control and error reporting. It instantiates inside the CPU top in place of the old converter.

## Interface
- `CLK_DIV`, default 52: clk cycles per oversample tick; 8 ticks form one bit time. Legal range is 2..1023.
- `DATA_BITS`, default 8: character width. Legal range is 5..8.
- `RX_DEPTH`, default 4: receive FIFO entries. Must be a power of two, 2..64.
- `TX_DEPTH`, default 4: transmit FIFO entries. Must be a power of two, 2..64.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `rxd`  in  1  serial input. Idle level is 1.
- `rdata`  out  8  head of the RX FIFO, zero-extended above `DATA_BITS`.
- `rflag`  out  1  RX FIFO not empty.
- `rclr`  in  1  pop RX FIFO (KCC).
- `rbusy`  out  1  receiver is inside a frame.
- `rts_n`  out  1  1 when the RX FIFO has 1 or fewer free entries.
- `txd`  out  1  serial output.
- `tdata`  in  8  character to transmit. Only bits `[DATA_BITS-1:0]` are used.
- `tload`  in  1  push `tdata` into the TX FIFO (TLS).
- `tflag`  out  1  sticky "character sent" flag.
- `tclr`  in  1  clear `tflag`.
- `tfull`  out  1  TX FIFO full.
- `tbusy`  out  1  transmitter is inside a frame.
- `cts_n`  in  1  clear-to-send, active low. Asynchronous input.
- `ferr`  out  1  sticky framing error.
- `oerr`  out  1  sticky overrun.
- `perr`  out  1  sticky parity error.
- `eclr`  in  1  clear `ferr`, `oerr` and `perr`.

## Operation
- Tick generator: a counter runs 0..`CLK_DIV`-1. `tick` is high for one clk when the counter wraps. It is free-running and shared by RX and TX.
- RX sync: `rxd` and `cts_n` each pass through a 2-flop synchroniser. All logic uses the synchronised values `rxs` and `ctss_n`.
- RX FSM states: IDLE, START, DATA, [PAR], STOP.
  - IDLE→START on a tick with `rxs`=0.
  - START: after 4 ticks, sample. If `rxs`=1 the start was a glitch, so return to IDLE and push nothing. If `rxs`=0, go to DATA.
  - DATA: sample every 8 ticks, LSB first, for `DATA_BITS` bits. Then go to PAR if enabled, otherwise STOP.
  - STOP: sample after 8 ticks.
    - `rxs`=0: set `ferr`, discard the character.
    - `rxs`=1 and FIFO full: set `oerr`, discard the character. FIFO contents are unchanged.
    - Otherwise: push the character.
  - After the STOP sample, return to IDLE.
- `rbusy` is 1 in every RX state except IDLE.
- RX FIFO is first-word-fall-through. `rdata` is valid whenever `rflag`=1. When `rflag`=0, `rdata` holds the last popped value.
  - `rclr` while empty: ignored.
  - Push and `rclr` in the same cycle while full: the pop frees the entry and the push succeeds. No overrun.
- TX FIFO: `tload` while `tfull`=1 is ignored. A push and a pop in the same cycle are both honoured.
- TX FSM states: IDLE, START, DATA, [PAR], STOP.
  - IDLE→START on a tick when the FIFO is not empty and `ctss_n`=0. The FIFO pops into the shift register at that point.
  - Each bit lasts 8 ticks. Frame order is: start bit 0, data LSB first, optional parity, one stop bit 1.
  - At the end of the stop bit: set `tflag`, then go to IDLE.
  - IDLE may restart on the next tick. Back-to-back frames therefore have zero to one tick of gap, never more.
- `txd`=1 in IDLE. `tbusy` is 1 in every TX state except IDLE.
- `cts_n` is sampled only at frame start. Deasserting it mid-frame does not truncate the frame.
- Flag precedence:
  - `tclr` beats a simultaneous `tflag` set.
  - `eclr` beats a simultaneous error set.
  - `rclr` has no effect on the error flags.

## Timing
- Reset values:
  - `txd`=1.
  - `rflag`, `rbusy`, `tflag`, `tbusy`, `tfull`, `ferr`, `oerr`, `perr` all 0.
  - `rts_n`=0 (the FIFO is empty).
  - `rdata`=0.
  - Both FIFOs empty; tick counter at 0.
- Reset mid-frame aborts the frame and empties both FIFOs immediately.
- RX latency: `rflag` rises 1 clk after the STOP-sample tick. That is about (1.5 + `DATA_BITS` [+1]) bit times after the falling start edge, plus 2 clk of synchroniser delay.
- TX latency: the start bit begins 1 clk after the first tick following a `tload` into an empty FIFO.
- `tfull` and `rts_n` are registered and update 1 clk after the push or pop that causes them.
- `rflag` falls 1 clk after an `rclr` that empties the FIFO.

## Configuration
- `UART_PARITY_EN` defined:
  - One even-parity bit follows the data on both TX and RX.
  - On RX, a parity mismatch sets `perr`, but the character is still pushed.
- `UART_PARITY_EN` undefined:
  - No parity bit is sent or expected.
  - `perr` is tied to 0.

## Test plan
- Defaults, no parity. Drive `rxd` with 0x41 framed 8N1 at 8×52 clk per bit. Required: `rflag`=1, `rdata`=0x41, `ferr`=0, `rbusy` back to 0.
- `tload` with 0x55 and `cts_n`=0. Required: `txd` shows 0,1,0,1,0,1,0,1,0,1, each bit 416 clk. `tflag` rises at the end of the stop bit. `tclr` returns it to 0.
- Receive 5 characters 0x01..0x05 with no `rclr`. Required:
  - `rts_n`=1 after the 3rd character.
  - `oerr`=1 after the 5th.
  - `rclr` pops yield 0x01..0x04.
  - `eclr` clears `oerr`.
- Hold `cts_n`=1 and `tload` 0xAA, 0xBB, 0xCC, 0xDD. Required:
  - `tfull`=1 and `txd` stays 1.
  - A 5th `tload` is ignored.
  - After `cts_n`=0, four back-to-back frames go out in order 0xAA..0xDD.
- Send a frame with stop bit 0. Required: `ferr`=1 and `rflag` stays 0. Also send a 2-tick low glitch on `rxd`. Required: no push, `rbusy` back to 0 after 4 ticks.
- `UART_PARITY_EN` defined, `DATA_BITS`=7. Send 0x03 with parity 1. Required: `perr`=1 and `rdata`=0x03. Assert reset mid-TX-frame. Required: `txd`=1 and `tbusy`=0 immediately.

Source files
------------

// File: rtl/serial_fifo_uart.sv
// serial_fifo_uart: full-duplex UART with bit-clock divider, RX/TX FIFOs, CTS/RTS and PDP-8 TTY flags.
// Define UART_PARITY_EN to add one even-parity bit in both directions.
module serial_fifo_uart #(
    parameter int CLK_DIV   = 52,
    parameter int DATA_BITS = 8,
    parameter int RX_DEPTH  = 4,
    parameter int TX_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rflag,
    input  logic       rclr,
    output logic       rbusy,
    output logic       rts_n,
    output logic       txd,
    input  logic [7:0] tdata,
    input  logic       tload,
    output logic       tflag,
    input  logic       tclr,
    output logic       tfull,
    output logic       tbusy,
    input  logic       cts_n,
    output logic       ferr,
    output logic       oerr,
    output logic       perr,
    input  logic       eclr
);
`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    localparam int CW  = $clog2(CLK_DIV);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
    localparam logic [7:0] MASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic          rx_s1_q, rxs_q, cts_s1_q, ctss_n_q;
    state_t        rstate_q, rstate_d, tstate_q, tstate_d;
    logic [2:0]    rtick_q, rtick_d, rbit_q, rbit_d, ttick_q, ttick_d, tbit_q, tbit_d;
    logic [7:0]    rsh_q, rsh_d, tsh_q, tsh_d, rlast_q, rlast_d;
    logic          tpar_q, tpar_d, txd_q, txd_d;
    logic          r_stop, r_perr, r_push, r_pop, r_full, t_push, t_pop, t_done;
    logic [7:0]    rmem [RX_DEPTH];
    logic [7:0]    tmem [TX_DEPTH];
    logic [RAW-1:0] rwp_q, rwp_d, rrp_q, rrp_d;
    logic [RAW:0]   rcnt_q, rcnt_d;
    logic [TAW-1:0] twp_q, twp_d, trp_q, trp_d;
    logic [TAW:0]   tcnt_q, tcnt_d;
    logic          rts_n_q, rts_n_d, tfull_q, tfull_d, tflag_q, tflag_d;
    logic          ferr_q, ferr_d, oerr_q, oerr_d, perr_q, perr_d;

    assign tick  = cnt_q == CW'(CLK_DIV - 1);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    // Receiver: START samples mid-start-bit after 4 ticks, later bits every 8 ticks
    always_comb begin
        rstate_d = rstate_q;
        rtick_d  = rtick_q;
        rbit_d   = rbit_q;
        rsh_d    = rsh_q;
        r_stop   = 1'b0;
        r_perr   = 1'b0;
        if (tick) begin
            rtick_d = rtick_q + 3'd1;
            case (rstate_q)
                S_IDLE: if (!rxs_q) begin
                    rstate_d = S_START;
                    rtick_d  = '0;
                end
                S_START: if (rtick_q == 3'd3) begin
                    rstate_d = rxs_q ? S_IDLE : S_DATA;
                    rtick_d  = '0;
                    rbit_d   = '0;
                    rsh_d    = '0;
                end
                S_DATA: if (rtick_q == 3'd7) begin
                    rsh_d[rbit_q] = rxs_q;
                    rbit_d        = rbit_q + 3'd1;
                    if (rbit_q == LAST) rstate_d = PAR_EN ? S_PAR : S_STOP;
                end
                S_PAR: if (rtick_q == 3'd7) begin
                    r_perr   = rxs_q != ^rsh_q;
                    rstate_d = S_STOP;
                end
                default: if (rtick_q == 3'd7) begin
                    r_stop   = 1'b1;
                    rstate_d = S_IDLE;
                end
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign r_pop   = rclr && rcnt_q != '0;
    assign r_full  = rcnt_q == (RAW + 1)'(RX_DEPTH);
    assign r_push  = r_stop && rxs_q && (!r_full || r_pop);
    assign rcnt_d  = rcnt_q + (RAW + 1)'(r_push) - (RAW + 1)'(r_pop);
    assign rwp_d   = rwp_q + RAW'(r_push);
    assign rrp_d   = rrp_q + RAW'(r_pop);
    assign rlast_d = r_pop ? rmem[rrp_q] : rlast_q;
    assign rts_n_d = rcnt_d >= (RAW + 1)'(RX_DEPTH - 1);

    assign t_push  = tload && !tfull_q;
    assign tcnt_d  = tcnt_q + (TAW + 1)'(t_push) - (TAW + 1)'(t_pop);
    assign twp_d   = twp_q + TAW'(t_push);
    assign trp_d   = trp_q + TAW'(t_pop);
    assign tfull_d = tcnt_d == (TAW + 1)'(TX_DEPTH);

    // Transmitter: CTS is only looked at when leaving IDLE
    always_comb begin
        tstate_d = tstate_q;
        ttick_d  = ttick_q;
        tbit_d   = tbit_q;
        tsh_d    = tsh_q;
        tpar_d   = tpar_q;
        t_pop    = 1'b0;
        t_done   = 1'b0;
        if (tick) begin
            ttick_d = ttick_q + 3'd1;
            case (tstate_q)
                S_IDLE: if (tcnt_q != '0 && !ctss_n_q) begin
                    t_pop    = 1'b1;
                    tsh_d    = tmem[trp_q];
                    tpar_d   = ^tmem[trp_q];
                    ttick_d  = '0;
                    tstate_d = S_START;
                end
                S_START: if (ttick_q == 3'd7) begin
                    tstate_d = S_DATA;
                    tbit_d   = '0;
                end
                S_DATA: if (ttick_q == 3'd7) begin
                    tsh_d  = tsh_q >> 1;
                    tbit_d = tbit_q + 3'd1;
                    if (tbit_q == LAST) tstate_d = PAR_EN ? S_PAR : S_STOP;
                end
                S_PAR: if (ttick_q == 3'd7) tstate_d = S_STOP;
                default: if (ttick_q == 3'd7) begin
                    t_done   = 1'b1;
                    tstate_d = S_IDLE;
                end
            endcase
        end
        txd_d = tstate_d == S_START ? 1'b0 :
                tstate_d == S_DATA  ? tsh_d[0] :
                tstate_d == S_PAR   ? tpar_d : 1'b1;
    end

    assign tflag_d = !tclr && (tflag_q || t_done);
    assign ferr_d  = !eclr && (ferr_q || (r_stop && !rxs_q));
    assign oerr_d  = !eclr && (oerr_q || (r_stop && rxs_q && r_full && !r_pop));
    assign perr_d  = !eclr && (perr_q || r_perr);

    always_ff @(posedge clk) begin
        if (r_push) rmem[rwp_q] <= rsh_q;
        if (t_push) tmem[twp_q] <= tdata & MASK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            rx_s1_q  <= 1'b1;
            rxs_q    <= 1'b1;
            cts_s1_q <= 1'b1;
            ctss_n_q <= 1'b1;
            rstate_q <= S_IDLE;
            tstate_q <= S_IDLE;
            rtick_q  <= '0;
            rbit_q   <= '0;
            ttick_q  <= '0;
            tbit_q   <= '0;
            rsh_q    <= '0;
            tsh_q    <= '0;
            rlast_q  <= '0;
            tpar_q   <= 1'b0;
            txd_q    <= 1'b1;
            rwp_q    <= '0;
            rrp_q    <= '0;
            rcnt_q   <= '0;
            twp_q    <= '0;
            trp_q    <= '0;
            tcnt_q   <= '0;
            rts_n_q  <= 1'b0;
            tfull_q  <= 1'b0;
            tflag_q  <= 1'b0;
            ferr_q   <= 1'b0;
            oerr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rx_s1_q  <= rxd;
            rxs_q    <= rx_s1_q;
            cts_s1_q <= cts_n;
            ctss_n_q <= cts_s1_q;
            rstate_q <= rstate_d;
            tstate_q <= tstate_d;
            rtick_q  <= rtick_d;
            rbit_q   <= rbit_d;
            ttick_q  <= ttick_d;
            tbit_q   <= tbit_d;
            rsh_q    <= rsh_d;
            tsh_q    <= tsh_d;
            rlast_q  <= rlast_d;
            tpar_q   <= tpar_d;
            txd_q    <= txd_d;
            rwp_q    <= rwp_d;
            rrp_q    <= rrp_d;
            rcnt_q   <= rcnt_d;
            twp_q    <= twp_d;
            trp_q    <= trp_d;
            tcnt_q   <= tcnt_d;
            rts_n_q  <= rts_n_d;
            tfull_q  <= tfull_d;
            tflag_q  <= tflag_d;
            ferr_q   <= ferr_d;
            oerr_q   <= oerr_d;
            perr_q   <= perr_d;
        end
    end

    assign rdata = rcnt_q == '0 ? rlast_q : rmem[rrp_q];
    assign rflag = rcnt_q != '0;
    assign rbusy = rstate_q != S_IDLE;
    assign rts_n = rts_n_q;
    assign txd   = txd_q;
    assign tflag = tflag_q;
    assign tfull = tfull_q;
    assign tbusy = tstate_q != S_IDLE;
    assign ferr  = ferr_q;
    assign oerr  = oerr_q;
    assign perr  = PAR_EN & perr_q;
endmodule

// File: tb/tb_serial_fifo_uart.sv
// tb_serial_fifo_uart: bench for serial_fifo_uart at CLK_DIV=52 (416 clk per bit).
// Defining UART_PARITY_EN builds the 7-bit even-parity variant.
module tb_serial_fifo_uart;
    localparam int CD = 52;
    localparam int BT = 8 * CD;
`ifdef UART_PARITY_EN
    localparam int DB = 7;
    localparam int PE = 1;
`else
    localparam int DB = 8;
    localparam int PE = 0;
`endif
    localparam int NB = DB + PE + 2;
    localparam logic [7:0] MASK = 8'((1 << DB) - 1);

    logic       clk = 1'b0, reset = 1'b1, rxd = 1'b1, rclr = 1'b0, tload = 1'b0;
    logic       tclr = 1'b0, cts_n = 1'b1, eclr = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic [7:0] rdata;
    logic       rflag, rbusy, rts_n, txd, tflag, tfull, tbusy, ferr, oerr, perr;
    int         checks = 0, failures = 0;

    serial_fifo_uart #(.CLK_DIV(CD), .DATA_BITS(DB), .RX_DEPTH(4), .TX_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .rdata(rdata), .rflag(rflag), .rclr(rclr),
        .rbusy(rbusy), .rts_n(rts_n), .txd(txd), .tdata(tdata), .tload(tload),
        .tflag(tflag), .tclr(tclr), .tfull(tfull), .tbusy(tbusy), .cts_n(cts_n),
        .ferr(ferr), .oerr(oerr), .perr(perr), .eclr(eclr)
    );

    always #5 clk = ~clk;

    function automatic logic par(input logic [7:0] d);
        return ^(d & MASK);
    endfunction

    // Line bits in time order: start, data LSB first, [parity], stop; unused top bits stay 1
    function automatic logic [9:0] frame(input logic [7:0] d, input logic p, input logic stop);
        logic [9:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1+i] = d[i];
        if (PE == 1) f[1+DB] = p;
        f[NB-1] = stop;
        return f;
    endfunction

    task automatic send_rx(input logic [7:0] d, input logic p, input logic stop);
        logic [9:0] f;
        f = frame(d, p, stop);
        for (int i = 0; i < NB; i++) begin
            rxd = f[i];
            repeat (BT) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic capture_tx(input int bound, output logic [9:0] got, output logic ok);
        int n;
        n = 0;
        got = '1;
        while (txd !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        ok = txd === 1'b0;
        if (ok) begin
            repeat (BT / 2) @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                got[i] = txd;
                if (i < NB - 1) repeat (BT) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        cts_n = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({txd, rflag, rbusy, rts_n, tflag, tfull, tbusy, ferr, oerr, perr} !== 10'b10_0000_0000) begin
            failures++;
            $display("FAIL reset_state got=%b required=1000000000",
                     {txd, rflag, rbusy, rts_n, tflag, tfull, tbusy, ferr, oerr, perr});
        end
        checks++;
        if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h required=00", rdata); end
    endtask

    task automatic test_rx_basic;
        send_rx(8'h41, par(8'h41), 1'b1);
        checks++;
        if (rflag !== 1'b1) begin failures++; $display("FAIL rx_rflag got=%b required=1", rflag); end
        checks++;
        if (rdata !== 8'h41) begin failures++; $display("FAIL rx_rdata got=%h required=41", rdata); end
        checks++;
        if (ferr !== 1'b0) begin failures++; $display("FAIL rx_ferr got=%b required=0", ferr); end
        checks++;
        if (rbusy !== 1'b0) begin failures++; $display("FAIL rx_rbusy got=%b required=0", rbusy); end
        checks++;
        if (perr !== 1'b0) begin failures++; $display("FAIL rx_perr got=%b required=0", perr); end
        rclr = 1'b1;
        @(negedge clk);
        rclr = 1'b0;
        checks++;
        if (rflag !== 1'b0) begin failures++; $display("FAIL rx_pop_rflag got=%b required=0", rflag); end
        checks++;
        if (rdata !== 8'h41) begin failures++; $display("FAIL rx_hold_rdata got=%h required=41", rdata); end
    endtask

    task automatic test_tx_single;
        logic [9:0] got, exp;
        int n;
        exp = frame(8'h55, par(8'h55), 1'b1);
        got = '1;
        tdata = 8'h55;
        tload = 1'b1;
        @(negedge clk);
        tload = 1'b0;
        n = 0;
        while (txd !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (txd !== 1'b0) begin failures++; $display("FAIL tx_start got=%b required=0 after %0d clk", txd, n); end
        got[0] = txd;
        repeat (BT - 1) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin failures++; $display("FAIL tx_start_len got=%b at clk 415 required=0", txd); end
        @(negedge clk);
        got[1] = txd;
        for (int i = 2; i < NB; i++) begin
            repeat (BT) @(negedge clk);
            got[i] = txd;
        end
        checks++;
        if (got !== exp) begin failures++; $display("FAIL tx_bits got=%b required=%b", got, exp); end
        repeat (BT - 1) @(negedge clk);
        checks++;
        if ({tflag, tbusy} !== 2'b01) begin failures++; $display("FAIL tx_pre_flag tflag,tbusy got=%b required=01", {tflag, tbusy}); end
        @(negedge clk);
        checks++;
        if ({tflag, tbusy, txd} !== 3'b101) begin
            failures++;
            $display("FAIL tx_end tflag,tbusy,txd got=%b required=101", {tflag, tbusy, txd});
        end
        tclr = 1'b1;
        @(negedge clk);
        tclr = 1'b0;
        checks++;
        if (tflag !== 1'b0) begin failures++; $display("FAIL tx_tclr got=%b required=0", tflag); end
    endtask

    task automatic test_rx_overrun;
        for (int i = 1; i <= 5; i++) begin
            send_rx(8'(i), par(8'(i)), 1'b1);
            if (i == 2) begin
                checks++;
                if (rts_n !== 1'b0) begin failures++; $display("FAIL ovr_rts_n_2 got=%b required=0", rts_n); end
            end
            if (i == 3) begin
                checks++;
                if (rts_n !== 1'b1) begin failures++; $display("FAIL ovr_rts_n_3 got=%b required=1", rts_n); end
            end
            if (i == 4) begin
                checks++;
                if (oerr !== 1'b0) begin failures++; $display("FAIL ovr_oerr_4 got=%b required=0", oerr); end
            end
        end
        checks++;
        if ({oerr, rflag} !== 2'b11) begin failures++; $display("FAIL ovr_oerr_5 oerr,rflag got=%b required=11", {oerr, rflag}); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (rdata !== 8'(i)) begin failures++; $display("FAIL ovr_pop got=%h required=%h", rdata, 8'(i)); end
            rclr = 1'b1;
            @(negedge clk);
            rclr = 1'b0;
        end
        checks++;
        if ({rflag, rts_n, oerr} !== 3'b001) begin
            failures++;
            $display("FAIL ovr_drained rflag,rts_n,oerr got=%b required=001", {rflag, rts_n, oerr});
        end
        rclr = 1'b1;
        @(negedge clk);
        rclr = 1'b0;
        checks++;
        if ({rflag, rdata} !== {1'b0, 8'h04}) begin
            failures++;
            $display("FAIL ovr_empty_rclr rflag=%b rdata=%h required 0/04", rflag, rdata);
        end
        eclr = 1'b1;
        @(negedge clk);
        eclr = 1'b0;
        checks++;
        if (oerr !== 1'b0) begin failures++; $display("FAIL ovr_eclr got=%b required=0", oerr); end
    endtask

    task automatic test_tx_fifo;
        logic [7:0] vals [4];
        logic [9:0] got;
        logic       ok;
        int         lows;
        vals = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            tdata = vals[k];
            tload = 1'b1;
            @(negedge clk);
        end
        tload = 1'b0;
        checks++;
        if (tfull !== 1'b1) begin failures++; $display("FAIL fifo_tfull got=%b required=1", tfull); end
        tdata = 8'hEE;
        tload = 1'b1;
        @(negedge clk);
        tload = 1'b0;
        lows = 0;
        repeat (800) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || tbusy !== 1'b0) begin
            failures++;
            $display("FAIL fifo_cts_hold low_clks=%0d tbusy=%b required 0/0", lows, tbusy);
        end
        cts_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            capture_tx(k == 0 ? 400 : 270, got, ok);
            checks++;
            if (ok !== 1'b1) begin failures++; $display("FAIL fifo_frame_start k=%0d got=%b required=1", k, ok); end
            checks++;
            if (got !== frame(vals[k], par(vals[k]), 1'b1)) begin
                failures++;
                $display("FAIL fifo_frame k=%0d got=%b required=%b", k, got, frame(vals[k], par(vals[k]), 1'b1));
            end
        end
        checks++;
        if (tfull !== 1'b0) begin failures++; $display("FAIL fifo_tfull_clear got=%b required=0", tfull); end
        lows = 0;
        repeat (800) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || tflag !== 1'b1) begin
            failures++;
            $display("FAIL fifo_no_fifth low_clks=%0d tflag=%b required 0/1", lows, tflag);
        end
        tclr = 1'b1;
        @(negedge clk);
        tclr = 1'b0;
    endtask

    task automatic test_ferr_glitch;
        send_rx(8'h5A, par(8'h5A), 1'b0);
        repeat (600) @(negedge clk);
        checks++;
        if ({ferr, rflag, rbusy} !== 3'b100) begin
            failures++;
            $display("FAIL ferr_frame ferr,rflag,rbusy got=%b required=100", {ferr, rflag, rbusy});
        end
        eclr = 1'b1;
        @(negedge clk);
        eclr = 1'b0;
        checks++;
        if (ferr !== 1'b0) begin failures++; $display("FAIL ferr_eclr got=%b required=0", ferr); end
        rxd = 1'b0;
        repeat (2 * CD) @(negedge clk);
        checks++;
        if (rbusy !== 1'b1) begin failures++; $display("FAIL glitch_busy got=%b required=1", rbusy); end
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if ({rbusy, rflag, ferr} !== 3'b000) begin
            failures++;
            $display("FAIL glitch_idle rbusy,rflag,ferr got=%b required=000", {rbusy, rflag, ferr});
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity;
        send_rx(8'h03, 1'b1, 1'b1);
        checks++;
        if ({perr, rflag, ferr} !== 3'b110) begin
            failures++;
            $display("FAIL par_flags perr,rflag,ferr got=%b required=110", {perr, rflag, ferr});
        end
        checks++;
        if (rdata !== 8'h03) begin failures++; $display("FAIL par_rdata got=%h required=03", rdata); end
        rclr = 1'b1;
        eclr = 1'b1;
        @(negedge clk);
        rclr = 1'b0;
        eclr = 1'b0;
        checks++;
        if ({perr, rflag} !== 2'b00) begin failures++; $display("FAIL par_clear perr,rflag got=%b required=00", {perr, rflag}); end
    endtask
`endif

    task automatic test_reset_mid_tx;
        int n, lows;
        cts_n = 1'b0;
        tdata = 8'h33;
        tload = 1'b1;
        @(negedge clk);
        tdata = 8'h44;
        @(negedge clk);
        tload = 1'b0;
        n = 0;
        while (txd !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (600) @(negedge clk);
        checks++;
        if (tbusy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b required=1", tbusy); end
        reset = 1'b1;
        #1;
        checks++;
        if ({txd, tbusy, tfull} !== 3'b100) begin
            failures++;
            $display("FAIL rst_async txd,tbusy,tfull got=%b required=100", {txd, tbusy, tfull});
        end
        @(negedge clk);
        reset = 1'b0;
        lows = 0;
        repeat (800) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0 || tbusy !== 1'b0) begin
            failures++;
            $display("FAIL rst_flushed low_clks=%0d tbusy=%b required 0/0", lows, tbusy);
        end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_tx_single();
        test_rx_overrun();
        test_tx_fifo();
        test_ferr_glitch();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
